// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl: arm, level-crossing trigger, DEPTH-sample capture, framed UART TX stream.
// Define SCOPE_CAPTURE_CHECKSUM_EN to append an XOR checksum byte to every packet.
module scope_capture_ctrl #(
   parameter int         DEPTH        = 256,
   parameter int         ADDR_W       = 8,
   parameter int         TRIG_TIMEOUT = 27000000,
   parameter logic [7:0] HDR_BYTE     = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       arm,
   input  logic       sample_valid,
   input  logic [7:0] sample,
   input  logic [7:0] trig_level,
   input  logic       trig_falling,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic [2:0] state_o,
   output logic       frame_done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_CAP   = 3'd2;
   localparam logic [2:0] S_HDR   = 3'd3;
   localparam logic [2:0] S_FLAGS = 3'd4;
   localparam logic [2:0] S_DATA  = 3'd5;
`ifdef SCOPE_CAPTURE_CHECKSUM_EN
   localparam logic [2:0] S_CSUM  = 3'd6;
`endif

   localparam bit                TO_EN   = (TRIG_TIMEOUT != 0);
   localparam logic [31:0]       TO_LAST = 32'(TRIG_TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   logic [2:0]        state;
   logic [31:0]       tcnt;
   logic [7:0]        prev;
   logic              prev_ok;
   logic              fall_lat;
   logic              auto_flag;
   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;
   logic              fetch;
   logic [7:0]        rdata;
   logic [7:0]        mem [DEPTH];
`ifdef SCOPE_CAPTURE_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   logic              edge_hit;
   logic              to_hit;
   logic              we;
   logic [ADDR_W-1:0] waddr;

   assign edge_hit = sample_valid && prev_ok &&
                     (fall_lat ? (prev > trig_level && sample <= trig_level)
                               : (prev < trig_level && sample >= trig_level));
   assign to_hit   = TO_EN && (tcnt == TO_LAST);
   assign we       = (state == S_WAIT && edge_hit) ||
                     (state == S_CAP && sample_valid);
   assign waddr    = (state == S_CAP) ? wptr : '0;

   assign busy    = (state != S_IDLE);
   assign state_o = state;

   // Sample buffer: no reset, registered read feeds the data phase.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= sample;
      rdata <= mem[rptr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         tcnt       <= '0;
         prev       <= '0;
         prev_ok    <= 1'b0;
         fall_lat   <= 1'b0;
         auto_flag  <= 1'b0;
         wptr       <= '0;
         rptr       <= '0;
         fetch      <= 1'b0;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         frame_done <= 1'b0;
`ifdef SCOPE_CAPTURE_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         frame_done <= 1'b0;
`ifdef SCOPE_CAPTURE_CHECKSUM_EN
         if (tx_valid && tx_ready) csum <= csum ^ tx_data;
`endif
         case (state)
            S_IDLE: begin
               if (arm) begin
                  state    <= S_WAIT;
                  tcnt     <= '0;
                  prev_ok  <= 1'b0;
                  fall_lat <= trig_falling;
`ifdef SCOPE_CAPTURE_CHECKSUM_EN
                  csum     <= '0;
`endif
               end
            end
            S_WAIT: begin
               tcnt <= tcnt + 32'd1;
               if (sample_valid) begin
                  prev    <= sample;
                  prev_ok <= 1'b1;
               end
               // A real edge wins over the timeout in the same cycle.
               if (edge_hit) begin
                  wptr      <= ADDR_W'(1);
                  auto_flag <= 1'b0;
                  state     <= S_CAP;
               end else if (to_hit) begin
                  wptr      <= '0;
                  auto_flag <= 1'b1;
                  state     <= S_CAP;
               end
            end
            S_CAP: begin
               if (sample_valid) begin
                  wptr <= wptr + 1'b1;
                  if (wptr == LAST) state <= S_HDR;
               end
            end
            S_HDR: begin
               if (!tx_valid) begin
                  tx_data  <= HDR_BYTE;
                  tx_valid <= 1'b1;
               end else if (tx_ready) begin
                  tx_valid <= 1'b0;
                  state    <= S_FLAGS;
               end
            end
            S_FLAGS: begin
               if (!tx_valid) begin
                  tx_data  <= {6'b0, fall_lat, auto_flag};
                  tx_valid <= 1'b1;
               end else if (tx_ready) begin
                  tx_valid <= 1'b0;
                  rptr     <= '0;
                  fetch    <= 1'b0;
                  state    <= S_DATA;
               end
            end
            S_DATA: begin
               // fetch marks that rdata now holds mem[rptr].
               if (tx_valid) begin
                  if (tx_ready) begin
                     tx_valid <= 1'b0;
                     rptr     <= rptr + 1'b1;
                     if (rptr == LAST) begin
`ifdef SCOPE_CAPTURE_CHECKSUM_EN
                        state      <= S_CSUM;
`else
                        state      <= S_IDLE;
                        frame_done <= 1'b1;
`endif
                     end
                  end
               end else if (!fetch) begin
                  fetch <= 1'b1;
               end else begin
                  tx_data  <= rdata;
                  tx_valid <= 1'b1;
                  fetch    <= 1'b0;
               end
            end
`ifdef SCOPE_CAPTURE_CHECKSUM_EN
            S_CSUM: begin
               if (!tx_valid) begin
                  tx_data  <= csum;
                  tx_valid <= 1'b1;
               end else if (tx_ready) begin
                  tx_valid   <= 1'b0;
                  state      <= S_IDLE;
                  frame_done <= 1'b1;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
